// File: rtl/arb_wrr_pkg.sv
// Shared helpers for the weighted round-robin scheduler: index-width derivation,
// idle (reset/init/disable) grant values, the per-cycle decision kinds and a
// one-hot to index encoder.
package arb_wrr_pkg;

  localparam int unsigned MAX_N = 32;

  // Idle values that do not depend on parking configuration.
  localparam logic IDLE_GRANTED = 1'b0;
  localparam logic IDLE_LOCKED  = 1'b0;
  localparam logic IDLE_AGED    = 1'b0;

  // Per-cycle arbitration outcome, in priority order.
  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_LOCK,
    DEC_HOLD,
    DEC_PICK
  } dec_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // Index width; at least one bit even for degenerate sizes.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

  // Grant vector presented while idle: the park requester or nothing.
  function automatic logic [MAX_N-1:0] idle_grant(input int unsigned park_mode,
                                                  input int unsigned park_index);
    logic [MAX_N-1:0] g;
    g = '0;
    if (park_mode != 0) g[park_index] = 1'b1;
    return g;
  endfunction

  function automatic logic [4:0] onehot2idx(input logic [MAX_N-1:0] oh);
    logic [4:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (oh[i]) r = r | 5'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_wrr_sched_if.sv
// Requester-side bundle of the weighted round-robin scheduler.
// The aged flag exists only when ARB_WRR_AGING_EN is defined.
interface arb_wrr_sched_if
  import arb_wrr_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned W_W = 4
);
  localparam int unsigned IDX_W = idx_w(N);

  logic [N-1:0]     request;
  logic [N-1:0]     lock;
  logic [N-1:0]     mask;
  logic [N*W_W-1:0] weight;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_index;
  logic             granted;
  logic             parked;
  logic             locked;
`ifdef ARB_WRR_AGING_EN
  logic             aged;

  modport master (output request, lock, mask, weight,
                  input  grant, grant_index, granted, parked, locked, aged);
  modport slave  (input  request, lock, mask, weight,
                  output grant, grant_index, granted, parked, locked, aged);
`else
  modport master (output request, lock, mask, weight,
                  input  grant, grant_index, granted, parked, locked);
  modport slave  (input  request, lock, mask, weight,
                  output grant, grant_index, granted, parked, locked);
`endif

endinterface

// File: rtl/arb_wrr_rr_pick.sv
// Combinational rotate-priority picker: returns the first set bit of valid
// scanning from ptr+1 upward with wrap; ptr itself is checked last.
module arb_wrr_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Rotating scan; the first hit after ptr wins.
  always_comb begin
    int unsigned j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      j = (32'(ptr) + i) % N;
      if (!found && valid[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/arb_wrr_sched.sv
// Weighted round-robin arbiter: each tenure lasts up to max(weight,1) grant
// cycles, with lock, mask and park support. Outputs are registered.
// Optional: define ARB_WRR_AGING_EN for per-requester age counters that let a
// long-waiting requester win the next tenure boundary ahead of RR order.
module arb_wrr_sched
  import arb_wrr_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned PARK_MODE  = 1,
  parameter int unsigned PARK_INDEX = 0,
  parameter int unsigned W_W        = 4,
  parameter int unsigned AGE_W      = 6,
  parameter int unsigned AGE_LIMIT  = 48
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_n,
  input  logic enable,
  arb_wrr_sched_if.slave bus
);

  localparam int unsigned      IDX_W       = idx_w(N);
  localparam logic [N-1:0]     IDLE_GRANT  = N'(idle_grant(PARK_MODE, PARK_INDEX));
  localparam logic [IDX_W-1:0] IDLE_INDEX  = IDX_W'(onehot2idx(idle_grant(PARK_MODE, PARK_INDEX)));
  localparam logic             IDLE_PARKED = (PARK_MODE != 0);
  localparam logic [IDX_W-1:0] PTR_INIT    = IDX_W'(N - 1);

  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] grant_index_q, grant_index_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             granted_q, granted_d;
  logic             parked_q, parked_d;
  logic             locked_q, locked_d;
  logic [W_W-1:0]   credit_q, credit_d;
  logic             aged_q, aged_d;

  logic [N-1:0]     valid;
  logic             cur_valid;
  logic             rr_found;
  logic [IDX_W-1:0] rr_idx;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             win_aged;
  logic [W_W-1:0]   win_weight;
  dec_e             dec;

  assign valid     = bus.request & ~bus.mask;
  assign cur_valid = granted_q & valid[ptr_q];

  arb_wrr_rr_pick #(.N(N), .IDX_W(IDX_W)) u_rr_pick (
    .valid (valid),
    .ptr   (ptr_q),
    .found (rr_found),
    .idx   (rr_idx)
  );

`ifdef ARB_WRR_AGING_EN
  logic [AGE_W-1:0] age_q [N];
  logic [AGE_W-1:0] age_d [N];
  logic [N-1:0]     old_vec;
  logic             age_found;
  logic [IDX_W-1:0] age_idx;

  // Requesters that have waited past the limit and are still eligible now.
  always_comb begin
    old_vec = '0;
    for (int unsigned i = 0; i < N; i++) begin
      old_vec[i] = valid[i] && (age_q[i] >= AGE_W'(AGE_LIMIT));
    end
  end

  // Starting the scan after N-1 makes the picker a lowest-index-first search.
  arb_wrr_rr_pick #(.N(N), .IDX_W(IDX_W)) u_age_pick (
    .valid (old_vec),
    .ptr   (PTR_INIT),
    .found (age_found),
    .idx   (age_idx)
  );

  // Saturating wait counters; cleared while granted, masked or not requesting.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      age_d[i] = age_q[i];
      if (!init_n || !enable || !valid[i] || (granted_q && grant_q[i])) begin
        age_d[i] = '0;
      end else if (age_q[i] != '1) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
  end

  // Age counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) age_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) age_q[i] <= age_d[i];
    end
  end

  // Aged winner overrides the RR winner at a tenure boundary.
  always_comb begin
    win_found = rr_found;
    win_idx   = rr_idx;
    win_aged  = 1'b0;
    if (age_found) begin
      win_found = 1'b1;
      win_idx   = age_idx;
      win_aged  = 1'b1;
    end
  end

  assign bus.aged = aged_q;
`else
  // Without aging the RR winner is the only candidate.
  always_comb begin
    win_found = rr_found;
    win_idx   = rr_idx;
    win_aged  = 1'b0;
  end
`endif

  assign win_weight = bus.weight[32'(win_idx)*W_W +: W_W];

  // Classify this cycle: lock beats credit hold, which beats a new pick.
  always_comb begin
    dec = DEC_IDLE;
    if (cur_valid && bus.lock[ptr_q]) begin
      dec = DEC_LOCK;
    end else if (cur_valid && (credit_q != '0)) begin
      dec = DEC_HOLD;
    end else if (win_found) begin
      dec = DEC_PICK;
    end
  end

  // Next grant state; init and disable share the reset values.
  always_comb begin
    grant_d       = grant_q;
    grant_index_d = grant_index_q;
    ptr_d         = ptr_q;
    granted_d     = granted_q;
    parked_d      = parked_q;
    locked_d      = 1'b0;
    credit_d      = credit_q;
    aged_d        = aged_q;
    if (!init_n || !enable) begin
      grant_d       = IDLE_GRANT;
      grant_index_d = IDLE_INDEX;
      ptr_d         = PTR_INIT;
      granted_d     = IDLE_GRANTED;
      parked_d      = IDLE_PARKED;
      locked_d      = IDLE_LOCKED;
      credit_d      = '0;
      aged_d        = IDLE_AGED;
    end else begin
      unique case (dec)
        DEC_LOCK: locked_d = 1'b1;
        DEC_HOLD: credit_d = credit_q - W_W'(1);
        DEC_PICK: begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          grant_index_d    = win_idx;
          ptr_d            = win_idx;
          granted_d        = 1'b1;
          parked_d         = 1'b0;
          credit_d         = (win_weight == '0) ? '0 : win_weight - W_W'(1);
          aged_d           = win_aged;
        end
        default: begin
          // Pointer keeps the last grantee so rotation resumes after it.
          grant_d       = IDLE_GRANT;
          grant_index_d = IDLE_INDEX;
          granted_d     = IDLE_GRANTED;
          parked_d      = IDLE_PARKED;
          credit_d      = '0;
          aged_d        = IDLE_AGED;
        end
      endcase
    end
  end

  // Grant state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q       <= IDLE_GRANT;
      grant_index_q <= IDLE_INDEX;
      ptr_q         <= PTR_INIT;
      granted_q     <= IDLE_GRANTED;
      parked_q      <= IDLE_PARKED;
      locked_q      <= IDLE_LOCKED;
      credit_q      <= '0;
      aged_q        <= IDLE_AGED;
    end else begin
      grant_q       <= grant_d;
      grant_index_q <= grant_index_d;
      ptr_q         <= ptr_d;
      granted_q     <= granted_d;
      parked_q      <= parked_d;
      locked_q      <= locked_d;
      credit_q      <= credit_d;
      aged_q        <= aged_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_index = grant_index_q;
  assign bus.granted     = granted_q;
  assign bus.parked      = parked_q;
  assign bus.locked      = locked_q;

endmodule

// File: tb/tb_arb_wrr_sched.sv
// Self-checking bench for arb_wrr_sched (N=4, parking on requester 2).
// Expected outputs are queued when stimulus is applied and compared one cycle later.
module tb_arb_wrr_sched;

  localparam int unsigned N   = 4;
  localparam int unsigned W_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic init_n;
  logic enable;

  arb_wrr_sched_if #(.N(N), .W_W(W_W)) bus ();

  arb_wrr_sched #(
    .N(N), .PARK_MODE(1), .PARK_INDEX(2), .W_W(W_W), .AGE_W(6), .AGE_LIMIT(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .init_n (init_n),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] idx;
    logic       granted;
    logic       parked;
    logic       locked;
    logic       aged;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t e_gnt(input int unsigned i, input logic lk, input logic ag);
    exp_t e;
    e.grant   = 4'b0001 << i;
    e.idx     = 2'(i);
    e.granted = 1'b1;
    e.parked  = 1'b0;
    e.locked  = lk;
    e.aged    = ag;
    return e;
  endfunction

  function automatic exp_t e_idle();
    exp_t e;
    e.grant   = 4'b0100;
    e.idx     = 2'd2;
    e.granted = 1'b0;
    e.parked  = 1'b1;
    e.locked  = 1'b0;
    e.aged    = 1'b0;
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t a;
    a.grant   = bus.grant;
    a.idx     = bus.grant_index;
    a.granted = bus.granted;
    a.parked  = bus.parked;
    a.locked  = bus.locked;
`ifdef ARB_WRR_AGING_EN
    a.aged    = bus.aged;
`else
    a.aged    = 1'b0;
`endif
    return a;
  endfunction

  task automatic drive(input logic [3:0] req, input logic [3:0] lk, input logic [3:0] msk);
    bus.request = req;
    bus.lock    = lk;
    bus.mask    = msk;
  endtask

  task automatic do_init();
    exp_t e, a;
    init_n = 1'b0;
    drive(4'b1111, 4'b0000, 4'b0000);
    sb.push_back(e_idle());
    @(posedge clk); #1;
    e = sb.pop_front(); a = observe(); n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL init: got %b want %b (grant,idx,granted,parked,locked,aged)", a, e);
    end
    init_n = 1'b1;
    drive(4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic test_reset();
    exp_t e, a;
    @(posedge clk); #1;
    sb.push_back(e_idle());
    e = sb.pop_front(); a = observe(); n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL reset: got %b want %b", a, e);
    end
    rst_n = 1'b1;
    sb.push_back(e_idle());
    @(posedge clk); #1;
    e = sb.pop_front(); a = observe(); n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL reset_idle: got %b want %b", a, e);
    end
  endtask

  task automatic test_rr_wrap();
    int unsigned seq [5] = '{0, 1, 2, 3, 0};
    exp_t e, a;
    bus.weight = 16'h1111;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) begin
        drive(4'b1111, 4'b0000, 4'b0000);
        sb.push_back(e_gnt(seq[k], 1'b0, 1'b0));
      end else begin
        drive(4'b0000, 4'b0000, 4'b0000);
        sb.push_back(e_idle());
      end
      @(posedge clk); #1;
      e = sb.pop_front(); a = observe(); n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL rr_wrap[%0d]: got %b want %b", k, a, e);
      end
    end
  endtask

  task automatic test_weighted();
    int unsigned seq [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    exp_t e, a;
    bus.weight = {4'd1, 4'd1, 4'd1, 4'd3};
    for (int k = 0; k < 8; k++) begin
      drive(4'b0011, 4'b0000, 4'b0000);
      sb.push_back(e_gnt(seq[k], 1'b0, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); a = observe(); n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL weighted[%0d]: got %b want %b", k, a, e);
      end
    end
  endtask

  task automatic test_lock_mask();
    exp_t e, a;
    bus.weight = 16'h1111;
    for (int k = 0; k < 9; k++) begin
      if (k < 7) drive(4'b0011, 4'b0010, 4'b0000);
      else       drive(4'b0011, 4'b0010, 4'b0010);
      if (k == 0)      sb.push_back(e_gnt(0, 1'b0, 1'b0));
      else if (k == 1) sb.push_back(e_gnt(1, 1'b0, 1'b0));
      else if (k < 7)  sb.push_back(e_gnt(1, 1'b1, 1'b0));
      else             sb.push_back(e_gnt(0, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); a = observe(); n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL lock_mask[%0d]: got %b want %b", k, a, e);
      end
    end
    drive(4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic test_drop_and_reset();
    exp_t e, a;
    bus.weight = {4'd1, 4'd1, 4'd4, 4'd3};
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        drive(4'b0011, 4'b0000, 4'b0000);
        sb.push_back(e_gnt(0, 1'b0, 1'b0));
      end else begin
        drive(4'b0010, 4'b0000, 4'b0000);
        sb.push_back(e_gnt(1, 1'b0, 1'b0));
      end
      @(posedge clk); #1;
      e = sb.pop_front(); a = observe(); n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL drop[%0d]: got %b want %b", k, a, e);
      end
    end
    rst_n = 1'b0;
    sb.push_back(e_idle());
    #1;
    e = sb.pop_front(); a = observe(); n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL reset_mid_tenure: got %b want %b", a, e);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.push_back(e_gnt(1, 1'b0, 1'b0));
    @(posedge clk); #1;
    e = sb.pop_front(); a = observe(); n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL after_reset: got %b want %b", a, e);
    end
    drive(4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic test_zero_weight_enable();
    exp_t e, a;
    bus.weight = 16'h0000;
    for (int k = 0; k < 7; k++) begin
      enable = 1'b1;
      case (k)
        0: begin drive(4'b0110, 4'b0000, 4'b0000); sb.push_back(e_gnt(1, 1'b0, 1'b0)); end
        1: begin drive(4'b0110, 4'b0000, 4'b0000); sb.push_back(e_gnt(2, 1'b0, 1'b0)); end
        2: begin drive(4'b0110, 4'b0000, 4'b0000); sb.push_back(e_gnt(1, 1'b0, 1'b0)); end
        3: begin drive(4'b0000, 4'b0000, 4'b0000); sb.push_back(e_idle()); end
        4: begin drive(4'b0110, 4'b0000, 4'b0000); sb.push_back(e_gnt(2, 1'b0, 1'b0)); end
        5: begin drive(4'b0110, 4'b0000, 4'b0000); enable = 1'b0; sb.push_back(e_idle()); end
        default: begin drive(4'b0110, 4'b0000, 4'b0000); sb.push_back(e_gnt(1, 1'b0, 1'b0)); end
      endcase
      @(posedge clk); #1;
      e = sb.pop_front(); a = observe(); n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL zero_weight_enable[%0d]: got %b want %b", k, a, e);
      end
    end
    drive(4'b0000, 4'b0000, 4'b0000);
  endtask

`ifdef ARB_WRR_AGING_EN
  task automatic test_aging();
    exp_t e, a;
    bus.weight = {4'd1, 4'd1, 4'd1, 4'd15};
    for (int k = 0; k < 17; k++) begin
      drive(4'b0101, 4'b0000, 4'b0000);
      if (k < 15)       sb.push_back(e_gnt(0, 1'b0, 1'b0));
      else if (k == 15) sb.push_back(e_gnt(2, 1'b0, 1'b1));
      else              sb.push_back(e_gnt(0, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); a = observe(); n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL aging[%0d]: got %b want %b", k, a, e);
      end
    end
    drive(4'b0000, 4'b0000, 4'b0000);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    init_n     = 1'b1;
    enable     = 1'b1;
    bus.weight = 16'h1111;
    drive(4'b0000, 4'b0000, 4'b0000);
    test_reset();
    test_rr_wrap();
    do_init();
    test_weighted();
    do_init();
    test_lock_mask();
    do_init();
    test_drop_and_reset();
    do_init();
    test_zero_weight_enable();
`ifdef ARB_WRR_AGING_EN
    do_init();
    test_aging();
`endif
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
